// File: rtl/mctrl_pkg.sv
// rtl/mctrl_pkg.sv - shared types and encodings for the multicycle MIPS control unit
package mctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUB_REGB  = 2'b00;
   localparam logic [1:0] ALUB_FOUR  = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUMODE_ADD   = 2'b00;
   localparam logic [1:0] ALUMODE_SUB   = 2'b01;
   localparam logic [1:0] ALUMODE_FUNCT = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - control unit <-> datapath signal bundle
interface mc_control_fsm_if;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;

   logic       pc_en;
   logic       ir_write;
   logic       iord;
   logic       mem_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic [2:0] alu_ctrl;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, pc_src, alu_ctrl, illegal_op, state
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, pc_src, alu_ctrl, illegal_op, state
   );

endinterface

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - ALU operation decoder (forced ADD, forced SUB, or from funct)
module alu_ctrl_dec
   import mctrl_pkg::*;
(
   input  logic [5:0] funct,
   input  logic [1:0] mode,
   output logic [2:0] alu_ctrl,
   output logic       funct_valid
);

   logic [2:0] fn_code;

   always_comb begin
      funct_valid = 1'b1;
      fn_code     = ALU_ADD;
      case (funct)
         FN_ADD:  fn_code = ALU_ADD;
         FN_SUB:  fn_code = ALU_SUB;
         FN_AND:  fn_code = ALU_AND;
         FN_OR:   fn_code = ALU_OR;
         FN_SLT:  fn_code = ALU_SLT;
         default: funct_valid = 1'b0;
      endcase
   end

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (mode)
         ALUMODE_SUB:   alu_ctrl = ALU_SUB;
         ALUMODE_FUNCT: alu_ctrl = fn_code;
         default:       alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS control FSM; MCTRL_ADDI_EN enables addi decode
module mc_control_fsm
   import mctrl_pkg::*;
#(
   parameter bit FETCH_ONLY_STALL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   mc_control_fsm_if.master bus
);

   state_e     state_q, state_d;
   logic       is_lw_q, is_lw_d;

   logic       pc_en, ir_write, iord, mem_write, reg_write;
   logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, pc_src, alu_mode;
   logic [2:0] dec_alu_ctrl;
   logic       funct_valid;
   logic       data_ready;

   // Data accesses may be configured to never stall; instruction fetch always does.
   assign data_ready = bus.mem_ready | FETCH_ONLY_STALL;

   alu_ctrl_dec u_alu_ctrl_dec (
      .funct       (bus.funct),
      .mode        (alu_mode),
      .alu_ctrl    (dec_alu_ctrl),
      .funct_valid (funct_valid)
   );

   always_comb begin
      state_d    = state_q;
      is_lw_d    = is_lw_q;
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = ALUB_REGB;
      pc_src     = PCSRC_ALU;
      alu_mode   = ALUMODE_ADD;
      illegal_op = 1'b0;

      case (state_q)
         S_FETCH: begin
            alu_src_b = ALUB_FOUR;
            ir_write  = bus.mem_ready;
            pc_en     = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = ALUB_IMMSH;
            // MEMADR picks lw vs sw after opcode may have moved on, so remember it here.
            is_lw_d   = (bus.opcode == OP_LW);
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE: begin
                  if (funct_valid) begin
                     state_d = S_EXECUTE;
                  end else begin
                     illegal_op = 1'b1;
                     state_d    = S_FETCH;
                  end
               end
               OP_BEQ: state_d = S_BRANCH;
               OP_J:   state_d = S_JUMP;
`ifdef MCTRL_ADDI_EN
               OP_ADDI: state_d = S_ADDIEXEC;
`else
               OP_ADDI: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_IMM;
            state_d   = is_lw_q ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord = 1'b1;
            if (data_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (data_ready) state_d = S_FETCH;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_mode  = ALUMODE_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_mode  = ALUMODE_SUB;
            pc_src    = PCSRC_ALUOUT;
            pc_en     = bus.zero;
            state_d   = S_FETCH;
         end
`ifdef MCTRL_ADDI_EN
         S_ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_IMM;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
`endif
         S_JUMP: begin
            pc_src  = PCSRC_JUMP;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // While reset is held, no strobe may reach the datapath, even combinationally.
      if (!rst_n) begin
         pc_en      = 1'b0;
         ir_write   = 1'b0;
         iord       = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = ALUB_REGB;
         pc_src     = PCSRC_ALU;
         alu_mode   = ALUMODE_ADD;
         illegal_op = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         is_lw_q <= 1'b0;
      end else begin
         state_q <= state_d;
         is_lw_q <= is_lw_d;
      end
   end

   assign bus.pc_en      = pc_en;
   assign bus.ir_write   = ir_write;
   assign bus.iord       = iord;
   assign bus.mem_write  = mem_write;
   assign bus.reg_write  = reg_write;
   assign bus.reg_dst    = reg_dst;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.alu_src_a  = alu_src_a;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.pc_src     = pc_src;
   assign bus.alu_ctrl   = dec_alu_ctrl;
   assign bus.illegal_op = illegal_op;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
module tb_mc_control_fsm;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mc_control_fsm_if bus ();

   mc_control_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
      logic [1:0] alu_src_b, pc_src;
      logic [2:0] alu_ctrl;
      logic       illegal;
   } out_t;

   typedef struct packed {
      logic       mr, z;
      logic [5:0] op, fn;
      out_t       e;
   } item_t;

   item_t q[$];
   int    errors = 0;
   int    checks = 0;
   string tag;

   function automatic logic fn_ok(input logic [5:0] fn);
      return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   endfunction

   function automatic logic [2:0] fn_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic out_t reset_out();
      out_t r;
      r = '0;
      r.alu_ctrl = 3'b010;
      return r;
   endfunction

   function automatic out_t exp_out(input logic [3:0] st, input logic mr, input logic z,
                                    input logic [5:0] fn, input logic ill);
      out_t e;
      e = reset_out();
      e.st = st;
      case (st)
         4'd0:  begin e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
         4'd1:  begin e.alu_src_b = 2'b11; e.illegal = ill; end
         4'd2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
         4'd3:  e.iord = 1'b1;
         4'd4:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
         4'd5:  begin e.iord = 1'b1; e.mem_write = 1'b1; end
         4'd6:  begin e.alu_src_a = 1'b1; e.alu_ctrl = fn_alu(fn); end
         4'd7:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
         4'd8:  begin e.alu_src_a = 1'b1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01; e.pc_en = z; end
         4'd9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
         4'd10: e.reg_write = 1'b1;
         4'd11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.st         = bus.state;
      o.pc_en      = bus.pc_en;
      o.ir_write   = bus.ir_write;
      o.iord       = bus.iord;
      o.mem_write  = bus.mem_write;
      o.reg_write  = bus.reg_write;
      o.reg_dst    = bus.reg_dst;
      o.mem_to_reg = bus.mem_to_reg;
      o.alu_src_a  = bus.alu_src_a;
      o.alu_src_b  = bus.alu_src_b;
      o.pc_src     = bus.pc_src;
      o.alu_ctrl   = bus.alu_ctrl;
      o.illegal    = bus.illegal_op;
      return o;
   endfunction

   // opcode/funct are scrambled outside DECODE/EXECUTE so any late sampling shows up.
   task automatic add_cyc(input logic [3:0] st, input logic mr, input logic z,
                          input logic [5:0] op, input logic [5:0] fn, input logic ill);
      item_t it;
      it.mr = mr;
      it.z  = z;
      it.op = (st == 4'd1 || st == 4'd6) ? op : ~op;
      it.fn = (st == 4'd1 || st == 4'd6) ? fn : ~fn;
      it.e  = exp_out(st, mr, z, fn, ill);
      q.push_back(it);
   endtask

   task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fstall, input int mstall, input logic omr);
      logic legal;
      for (int i = 0; i < fstall; i++) add_cyc(4'd0, 1'b0, z, op, fn, 1'b0);
      add_cyc(4'd0, 1'b1, z, op, fn, 1'b0);
      case (op)
         6'b100011, 6'b101011, 6'b000100, 6'b000010: legal = 1'b1;
         6'b000000: legal = fn_ok(fn);
`ifdef MCTRL_ADDI_EN
         6'b001000: legal = 1'b1;
`endif
         default: legal = 1'b0;
      endcase
      add_cyc(4'd1, omr, z, op, fn, !legal);
      if (legal) begin
         case (op)
            6'b100011: begin
               add_cyc(4'd2, omr, z, op, fn, 1'b0);
               for (int i = 0; i < mstall; i++) add_cyc(4'd3, 1'b0, z, op, fn, 1'b0);
               add_cyc(4'd3, 1'b1, z, op, fn, 1'b0);
               add_cyc(4'd4, omr, z, op, fn, 1'b0);
            end
            6'b101011: begin
               add_cyc(4'd2, omr, z, op, fn, 1'b0);
               for (int i = 0; i < mstall; i++) add_cyc(4'd5, 1'b0, z, op, fn, 1'b0);
               add_cyc(4'd5, 1'b1, z, op, fn, 1'b0);
            end
            6'b000000: begin
               add_cyc(4'd6, omr, z, op, fn, 1'b0);
               add_cyc(4'd7, omr, z, op, fn, 1'b0);
            end
            6'b000100: add_cyc(4'd8, omr, z, op, fn, 1'b0);
            6'b001000: begin
               add_cyc(4'd9, omr, z, op, fn, 1'b0);
               add_cyc(4'd10, omr, z, op, fn, 1'b0);
            end
            default: add_cyc(4'd11, omr, z, op, fn, 1'b0);
         endcase
      end
   endtask

   task automatic drive(input item_t it);
      bus.mem_ready = it.mr;
      bus.zero      = it.z;
      bus.opcode    = it.op;
      bus.funct     = it.fn;
   endtask

   // Entered at posedge+1; each item drives one cycle and is checked at the falling edge.
   task automatic run_n(input int n);
      item_t it;
      out_t  obs;
      for (int i = 0; i < n && q.size() > 0; i++) begin
         it = q.pop_front();
         drive(it);
         @(negedge clk);
         obs = sample();
         checks++;
         if (obs !== it.e) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, i, obs, it.e);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_all();
      run_n(q.size());
   endtask

   task automatic check_reset_outputs(input string name);
      out_t obs;
      obs = sample();
      checks++;
      if (obs !== reset_out()) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, obs, reset_out());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      bus.zero = 1'b1;
      bus.opcode = 6'b100011;
      bus.funct = 6'b000000;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
   endtask

   task automatic test_lw();
      tag = "lw";
      push_instr(6'b100011, 6'b000000, 1'b0, 0, 0, 1'b1);
      run_all();
   endtask

   task automatic test_rtype();
      logic [5:0] fns [5];
      fns = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};
      tag = "rtype";
      foreach (fns[i]) push_instr(6'b000000, fns[i], 1'b0, 0, 0, 1'b1);
      run_all();
   endtask

   task automatic test_beq();
      tag = "beq";
      push_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b1);
      push_instr(6'b000100, 6'b000000, 1'b0, 0, 0, 1'b1);
      run_all();
   endtask

   task automatic test_sw_stall();
      tag = "sw_stall";
      push_instr(6'b101011, 6'b000000, 1'b0, 0, 3, 1'b1);
      run_all();
   endtask

   task automatic test_illegal();
      tag = "illegal";
      push_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b1);
      push_instr(6'b000000, 6'b000000, 1'b0, 0, 0, 1'b1);
      run_all();
   endtask

   task automatic test_addi();
      tag = "addi";
      push_instr(6'b001000, 6'b000000, 1'b0, 0, 0, 1'b1);
      run_all();
   endtask

   task automatic test_jump();
      tag = "jump";
      push_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b1);
      run_all();
   endtask

   task automatic test_stalls();
      tag = "stalls";
      push_instr(6'b100011, 6'b000000, 1'b0, 2, 2, 1'b1);
      push_instr(6'b000000, 6'b100010, 1'b1, 0, 0, 1'b0);
      push_instr(6'b000100, 6'b000000, 1'b1, 1, 0, 1'b0);
      run_all();
   endtask

   task automatic test_back_to_back();
      tag = "back_to_back";
      for (int i = 0; i < 6; i++) begin
         case ($urandom_range(0, 4))
            0: push_instr(6'b100011, 6'b000000, 1'b0, $urandom_range(0, 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            1: push_instr(6'b101011, 6'b000000, 1'b0, 0, $urandom_range(0, 2), 1'b1);
            2: push_instr(6'b000000, 6'b100101, 1'b0, 0, 0, 1'b1);
            3: push_instr(6'b000100, 6'b000000, 1'($urandom_range(0, 1)), 0, 0, 1'b1);
            default: push_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0);
         endcase
      end
      run_all();
   endtask

   task automatic test_reset_mid();
      item_t it;
      out_t  obs;
      tag = "reset_mid";
      push_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b1);
      run_n(3);
      it = q.pop_front();
      drive(it);
      @(negedge clk);
      obs = sample();
      checks++;
      if (obs !== it.e) begin
         errors++;
         $display("FAIL aluwb_before_reset: got %h expected %h", obs, it.e);
      end
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_async_mid_aluwb");
      @(posedge clk);
      #1 check_reset_outputs("reset_held_over_edge");
      rst_n = 1'b1;
      q.delete();
      tag = "after_reset";
      push_instr(6'b100011, 6'b000000, 1'b0, 0, 0, 1'b1);
      run_all();
   endtask

   initial begin
      test_reset();
      test_lw();
      test_rtype();
      test_beq();
      test_sw_stall();
      test_illegal();
      test_addi();
      test_jump();
      test_stalls();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
